dmem_resp: RTL and testbench

Data-memory responder: the slave end of the execute stage's load/store port. It accepts one request at a time (address, write data, size, read/write enable) over a valid/ready handshake, models a fixed access latency with a counter, commits byte/half/word writes into an internal word array, and returns zero-extended read data with an error flag. It sits between the execute-stage memory request signals and the register write-back path, standing in for the data SRAM.

---
 rtl/dmem_resp_pkg.sv | 22 ++
 rtl/dmem_resp_if.sv | 36 +++
 rtl/dmem_resp_lane.sv | 60 ++++++
 rtl/dmem_resp.sv | 183 ++++++++++++++++++
 tb/tb_dmem_resp.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg
// Shared definitions for the data-memory responder: access size encodings,
// FSM state encoding and the default byte address of array word 0.
// No ports (package).
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'd0,
    SIZE_H   = 2'd1,
    SIZE_W   = 2'd2,
    SIZE_ILL = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/dmem_resp_if.sv
// dmem_resp_if
// Load/store port between the execute stage (master) and the data-memory
// responder (slave).
//   req_valid/req_ready : request handshake
//   req_addr            : byte address
//   req_wdata           : right-aligned store data
//   req_size            : 0 byte, 1 half, 2 word, 3 illegal
//   req_r_en/req_w_en   : load / store enables
//   resp_valid/ready    : response handshake
//   resp_rdata          : zero-extended load data
//   resp_err            : access fault
interface dmem_resp_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [1:0]            req_size;
  logic                  req_r_en;
  logic                  req_w_en;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_size, req_r_en, req_w_en, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_size, req_r_en, req_w_en, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_resp_lane.sv
// dmem_resp_lane
// Combinational byte-lane steering for the data-memory responder.
//   size_i     : access size encoding
//   addr_lo_i  : addr[1:0] of the access
//   wdata_i    : right-aligned store data
//   rword_i    : full array word being accessed
//   wstrb_o    : per-byte write strobe
//   wword_o    : store data replicated onto its lanes
//   rdata_o    : selected load lane(s), zero-extended
// Low address bits that do not belong to the access size are ignored here
// (half uses addr[1], word uses lane 0); DMEM_RESP_MISALIGN_CHECK_EN in the
// top turns such accesses into errors before they reach the array.
module dmem_resp_lane
  import dmem_resp_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rShifted;

  // Byte loads shift the addressed lane down to bit 0.
  assign rShifted = rword_i >> {addr_lo_i, 3'b000};

  // Store data is replicated across all lanes so the strobe alone picks the
  // destination; load data is zero-extended from the selected lane(s).
  always_comb begin
    wstrb_o = 4'b0000;
    wword_o = 32'h0;
    rdata_o = 32'h0;
    case (size_e'(size_i))
      SIZE_B: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, rShifted[7:0]};
      end
      SIZE_H: begin
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
        rdata_o = addr_lo_i[1] ? {16'h0, rword_i[31:16]} : {16'h0, rword_i[15:0]};
      end
      SIZE_W: begin
        wstrb_o = 4'b1111;
        wword_o = wdata_i;
        rdata_o = rword_i;
      end
      default: begin
        wstrb_o = 4'b0000;
        wword_o = 32'h0;
        rdata_o = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp
// Data-memory responder: slave end of the execute-stage load/store port.
// Accepts one request at a time, waits a fixed LATENCY, commits stores into
// an internal word array and returns zero-extended load data plus an error.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : dmem_resp_if slave modport (request/response handshakes)
// Optional feature: define DMEM_RESP_MISALIGN_CHECK_EN to flag misaligned
// half/word accesses as errors; otherwise offending low bits are ignored.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 12,
  parameter int                    LATENCY    = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = BASE_ADDR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  dmem_resp_if.slave  bus
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [31:0]            wdata_q;
  logic [1:0]             size_q;
  logic                   r_en_q, w_en_q;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic                   reqReady, respValid, accept, commit, doWrite;
  logic [ADDR_WIDTH-1:0]  curAddr;
  logic [31:0]            curWdata;
  logic [1:0]             curSize;
  logic                   curREn, curWEn;
  logic [ADDR_WIDTH-3:0]  offWord;
  logic [DEPTH_LOG2-1:0]  wordIdx;
  logic                   belowBase, outOfRange, misalign, accessErr;
  logic [3:0]             wstrb;
  logic [31:0]            wword, laneRdata;

  assign accept = bus.req_valid && reqReady;

  // The edge entering RESP is the commit point. With LATENCY==1 that edge is
  // also the accept edge, so the live bus fields are used instead of latches.
  assign commit = ((state_q == IDLE) && accept && (LATENCY == 1)) ||
                  ((state_q == WAIT) && (cnt_q == '0));

  assign curAddr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
  assign curWdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
  assign curSize  = (state_q == IDLE) ? bus.req_size  : size_q;
  assign curREn   = (state_q == IDLE) ? bus.req_r_en  : r_en_q;
  assign curWEn   = (state_q == IDLE) ? bus.req_w_en  : w_en_q;

  // Word-granular offset from the base; any bit above DEPTH_LOG2 means the
  // index falls past the end of the array.
  assign offWord    = curAddr[ADDR_WIDTH-1:2] - BASE_ADDR[ADDR_WIDTH-1:2];
  assign belowBase  = curAddr < BASE_ADDR;
  assign outOfRange = |offWord[ADDR_WIDTH-3:DEPTH_LOG2];
  assign wordIdx    = offWord[DEPTH_LOG2-1:0];

`ifdef DMEM_RESP_MISALIGN_CHECK_EN
  assign misalign = ((curSize == SIZE_H) && curAddr[0]) ||
                    ((curSize == SIZE_W) && (curAddr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign accessErr = belowBase || outOfRange || misalign ||
                     (curSize == SIZE_ILL) || (curREn && curWEn);
  assign doWrite   = commit && curWEn && !curREn && !accessErr;

  dmem_resp_lane u_lane (
    .size_i    (curSize),
    .addr_lo_i (curAddr[1:0]),
    .wdata_i   (curWdata),
    .rword_i   (mem_q[wordIdx]),
    .wstrb_o   (wstrb),
    .wword_o   (wword),
    .rdata_o   (laneRdata)
  );

  // State and latency counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: WAIT counts down from LATENCY-2 and leaves on zero,
  // so RESP is entered LATENCY edges after the accept cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; req_ready is forced low while reset is held.
  always_comb begin
    reqReady  = rst_ni && (state_q == IDLE);
    respValid = (state_q == RESP);
  end

  assign bus.req_ready  = reqReady;
  assign bus.resp_valid = respValid;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // Request fields captured on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      r_en_q  <= 1'b0;
      w_en_q  <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      size_q  <= bus.req_size;
      r_en_q  <= bus.req_r_en;
      w_en_q  <= bus.req_w_en;
    end
  end

  // Load data is only returned for a clean load; stores, no-ops and faults
  // all answer with zero.
  always_comb begin
    err_d   = accessErr;
    rdata_d = '0;
    if (curREn && !curWEn && !accessErr) rdata_d = DATA_WIDTH'(laneRdata);
  end

  // Response registers hold while the consumer stalls in RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array: deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (doWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[wordIdx][b*8 +: 8] <= wword[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp
// Self-checking bench for dmem_resp: directed scenarios plus a randomized
// mix, all compared against a byte-addressed reference memory model.
module tb_dmem_resp;

  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk;
  logic rst_ni;
  int   checks;
  int   failures;

  byte unsigned modelMem [int];

  dmem_resp_if #(.ADDR_WIDTH(32)) bus ();

  dmem_resp #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH_LOG2 (12),
    .LATENCY    (LAT),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour: byte-addressed memory relative to BASE.
  function automatic void modelAccess(input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [1:0] size, input logic r, input logic w,
                                      output logic [31:0] rdata, output logic err);
    int          nBytes;
    logic [31:0] ea;
    err   = 1'b0;
    rdata = 32'h0;
    if (addr < BASE) err = 1'b1;
    else if (((addr - BASE) >> 2) >= 32'd4096) err = 1'b1;
    if (size == 2'd3) err = 1'b1;
    if (r && w) err = 1'b1;
`ifdef DMEM_RESP_MISALIGN_CHECK_EN
    if (size == 2'd1 && addr[0]) err = 1'b1;
    if (size == 2'd2 && addr[1:0] != 2'b00) err = 1'b1;
`endif
    if (err) return;
    nBytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    ea     = addr - (addr % nBytes);
    for (int i = 0; i < nBytes; i++) begin
      if (w) modelMem[int'(ea - BASE) + i] = wdata[8*i +: 8];
      if (r) rdata = rdata | (32'(modelMem[int'(ea - BASE) + i]) << (8*i));
    end
  endfunction

  // Drives one request, waits for its response, then completes the
  // response handshake. ok=0 if either wait ran out of budget.
  task automatic doTxn(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic r, input logic w,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output bit ok);
    int n;
    ok = 1'b1; lat = 0; rdata = 32'h0; err = 1'b0;
    @(negedge clk);
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_size = size;
    bus.req_r_en = r; bus.req_w_en = w; bus.req_valid = 1'b1;
    bus.resp_ready = 1'b0;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin ok = 1'b0; bus.req_valid = 1'b0; return; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!bus.resp_valid) begin ok = 1'b0; return; end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    @(negedge clk); bus.resp_ready = 1'b1;
    @(posedge clk); #1; bus.resp_ready = 1'b0;
  endtask

  task automatic applyIdle();
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_size = 2'd0; bus.req_r_en = 1'b0; bus.req_w_en = 1'b0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    bus.req_valid = 1'b1; bus.req_r_en = 1'b1; bus.req_size = 2'd2; bus.req_addr = BASE;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_ready got=%b want=0", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp_valid got=%b want=0", bus.resp_valid); end
    checks++; if (bus.resp_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_resp_rdata got=%h want=0", bus.resp_rdata); end
    checks++; if (bus.resp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp_err got=%b want=0", bus.resp_err); end
    @(negedge clk);
    applyIdle();
    rst_ni = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_req_ready got=%b want=1", bus.req_ready); end
  endtask

  // Give a 64-byte window known contents so random loads are predictable.
  task automatic test_init_window();
    logic [31:0] rd, md, wd; logic er, me; int lat; bit ok;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      modelAccess(BASE + 32'(4*i), wd, 2'd2, 1'b0, 1'b1, md, me);
      doTxn(BASE + 32'(4*i), wd, 2'd2, 1'b0, 1'b1, rd, er, lat, ok);
      checks++; if (!ok || er !== me) begin failures++; $display("[TB] FAIL init_store[%0d] ok=%0d err=%b want=%b", i, ok, er, me); end
    end
  endtask

  task automatic test_word();
    logic [31:0] rd, md; logic er, me; int lat; bit ok;
    modelAccess(32'h8000_0010, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b1, md, me);
    doTxn(32'h8000_0010, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b1, rd, er, lat, ok);
    checks++; if (!ok || lat != LAT) begin failures++; $display("[TB] FAIL store_word_latency ok=%0d got=%0d want=%0d", ok, lat, LAT); end
    checks++; if (er !== 1'b0) begin failures++; $display("[TB] FAIL store_word_err got=%b want=0", er); end
    modelAccess(32'h8000_0010, 32'h0, 2'd2, 1'b1, 1'b0, md, me);
    doTxn(32'h8000_0010, 32'h0, 2'd2, 1'b1, 1'b0, rd, er, lat, ok);
    checks++; if (!ok || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin failures++; $display("[TB] FAIL load_word got=%h err=%b want=deadbeef err=0", rd, er); end
  endtask

  task automatic test_subword();
    logic [31:0] rd, md; logic er, me; int lat; bit ok;
    modelAccess(32'h8000_0011, 32'h0000_00AB, 2'd0, 1'b0, 1'b1, md, me);
    doTxn(32'h8000_0011, 32'h0000_00AB, 2'd0, 1'b0, 1'b1, rd, er, lat, ok);
    doTxn(32'h8000_0011, 32'h0, 2'd0, 1'b1, 1'b0, rd, er, lat, ok);
    checks++; if (!ok || rd !== 32'h0000_00AB || er !== 1'b0) begin failures++; $display("[TB] FAIL load_byte got=%h err=%b want=000000ab err=0", rd, er); end
    doTxn(32'h8000_0010, 32'h0, 2'd2, 1'b1, 1'b0, rd, er, lat, ok);
    checks++; if (!ok || rd !== 32'hDEAD_ABEF) begin failures++; $display("[TB] FAIL load_after_byte got=%h want=deadabef", rd); end
    modelAccess(32'h8000_0012, 32'h0000_1234, 2'd1, 1'b0, 1'b1, md, me);
    doTxn(32'h8000_0012, 32'h0000_1234, 2'd1, 1'b0, 1'b1, rd, er, lat, ok);
    doTxn(32'h8000_0010, 32'h0, 2'd2, 1'b1, 1'b0, rd, er, lat, ok);
    checks++; if (!ok || rd !== 32'h1234_ABEF) begin failures++; $display("[TB] FAIL load_after_half got=%h want=1234abef", rd); end
    doTxn(32'h8000_0012, 32'h0, 2'd1, 1'b1, 1'b0, rd, er, lat, ok);
    checks++; if (!ok || rd !== 32'h0000_1234) begin failures++; $display("[TB] FAIL load_half got=%h want=00001234", rd); end
  endtask

  task automatic test_faults();
    logic [31:0] rd, md, word0; logic er, me; int lat; bit ok;
    modelAccess(BASE, 32'h0, 2'd2, 1'b1, 1'b0, word0, me);
    doTxn(32'h7FFF_FFFC, 32'h0, 2'd2, 1'b1, 1'b0, rd, er, lat, ok);
    checks++; if (!ok || er !== 1'b1 || rd !== 32'h0) begin failures++; $display("[TB] FAIL below_base got err=%b data=%h want err=1 data=0", er, rd); end
    modelAccess(32'h8000_4000, 32'hCAFE_F00D, 2'd2, 1'b0, 1'b1, md, me);
    doTxn(32'h8000_4000, 32'hCAFE_F00D, 2'd2, 1'b0, 1'b1, rd, er, lat, ok);
    checks++; if (!ok || er !== 1'b1) begin failures++; $display("[TB] FAIL past_end_err got=%b want=1", er); end
    doTxn(BASE, 32'h0, 2'd2, 1'b1, 1'b0, rd, er, lat, ok);
    checks++; if (!ok || rd !== word0) begin failures++; $display("[TB] FAIL past_end_no_write got=%h want=%h", rd, word0); end
    doTxn(32'h8000_0010, 32'h0, 2'd3, 1'b1, 1'b0, rd, er, lat, ok);
    checks++; if (!ok || er !== 1'b1 || rd !== 32'h0) begin failures++; $display("[TB] FAIL illegal_size got err=%b data=%h want err=1 data=0", er, rd); end
    doTxn(32'h8000_0010, 32'h0, 2'd2, 1'b1, 1'b1, rd, er, lat, ok);
    checks++; if (!ok || er !== 1'b1) begin failures++; $display("[TB] FAIL both_enables got=%b want=1", er); end
    doTxn(32'h8000_0010, 32'h5555_5555, 2'd2, 1'b0, 1'b0, rd, er, lat, ok);
    checks++; if (!ok || er !== 1'b0 || rd !== 32'h0) begin failures++; $display("[TB] FAIL no_enable got err=%b data=%h want err=0 data=0", er, rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, md; logic er, me; int lat; bit ok;
    modelAccess(32'h8000_0012, 32'h0, 2'd2, 1'b1, 1'b0, md, me);
    doTxn(32'h8000_0012, 32'h0, 2'd2, 1'b1, 1'b0, rd, er, lat, ok);
`ifdef DMEM_RESP_MISALIGN_CHECK_EN
    checks++; if (!ok || er !== 1'b1 || rd !== 32'h0) begin failures++; $display("[TB] FAIL misalign_word got err=%b data=%h want err=1 data=0", er, rd); end
`else
    checks++; if (!ok || er !== 1'b0 || rd !== 32'h1234_ABEF) begin failures++; $display("[TB] FAIL misalign_word got err=%b data=%h want err=0 data=1234abef", er, rd); end
`endif
    modelAccess(32'h8000_0013, 32'h0, 2'd1, 1'b1, 1'b0, md, me);
    doTxn(32'h8000_0013, 32'h0, 2'd1, 1'b1, 1'b0, rd, er, lat, ok);
    checks++; if (!ok || er !== me || rd !== md) begin failures++; $display("[TB] FAIL misalign_half got err=%b data=%h want err=%b data=%h", er, rd, me, md); end
  endtask

  task automatic test_backpressure();
    logic [31:0] md; logic me; int n;
    modelAccess(32'h8000_0010, 32'h0, 2'd2, 1'b1, 1'b0, md, me);
    @(negedge clk);
    bus.req_addr = 32'h8000_0010; bus.req_size = 2'd2; bus.req_r_en = 1'b1;
    bus.req_w_en = 1'b0; bus.req_valid = 1'b1; bus.resp_ready = 1'b0;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (!bus.resp_valid) begin failures++; $display("[TB] FAIL stall_resp_timeout got=0 want=1"); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid[%0d] got=%b want=1", c, bus.resp_valid); end
      checks++; if (bus.resp_rdata !== md) begin failures++; $display("[TB] FAIL stall_rdata[%0d] got=%h want=%h", c, bus.resp_rdata, md); end
      checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_req_ready[%0d] got=%b want=0", c, bus.req_ready); end
    end
    @(negedge clk); bus.resp_ready = 1'b1;
    @(posedge clk); #1; bus.resp_ready = 1'b0;
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL stall_release got valid=%b ready=%b want valid=0 ready=1", bus.resp_valid, bus.req_ready); end
  endtask

  task automatic test_abort();
    logic [31:0] rd, md; logic er, me; int lat; bit ok;
    @(negedge clk);
    bus.req_addr = 32'h8000_0010; bus.req_wdata = 32'h0; bus.req_size = 2'd2;
    bus.req_r_en = 1'b0; bus.req_w_en = 1'b1; bus.req_valid = 1'b1;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    #2 rst_ni = 1'b0;
    #2;
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL abort_in_reset got valid=%b ready=%b want 0/0", bus.resp_valid, bus.req_ready); end
    @(negedge clk); rst_ni = 1'b1;
    modelAccess(32'h8000_0010, 32'h0, 2'd2, 1'b1, 1'b0, md, me);
    doTxn(32'h8000_0010, 32'h0, 2'd2, 1'b1, 1'b0, rd, er, lat, ok);
    checks++; if (!ok || rd !== 32'h1234_ABEF || rd !== md) begin failures++; $display("[TB] FAIL abort_no_write got=%h want=1234abef", rd); end
  endtask

  task automatic test_random();
    logic [31:0] addr, wd, rd, md; logic [1:0] size; logic r, w, er, me; int lat, mode; bit ok;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 9))
        0:       addr = 32'h8000_4000 + $urandom_range(0, 255);
        1:       addr = 32'h7FFF_FF00 + $urandom_range(0, 255);
        default: addr = BASE + $urandom_range(0, 63);
      endcase
      size = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 5);
      r  = (mode == 0 || mode == 1 || mode == 4);
      w  = (mode == 2 || mode == 3 || mode == 4);
      wd = $urandom;
      modelAccess(addr, wd, size, r, w, md, me);
      doTxn(addr, wd, size, r, w, rd, er, lat, ok);
      checks++; if (!ok || lat != LAT) begin failures++; $display("[TB] FAIL rand_latency[%0d] ok=%0d got=%0d want=%0d", t, ok, lat, LAT); end
      checks++; if (er !== me) begin failures++; $display("[TB] FAIL rand_err[%0d] addr=%h size=%0d r=%b w=%b got=%b want=%b", t, addr, size, r, w, er, me); end
      checks++; if (rd !== md) begin failures++; $display("[TB] FAIL rand_rdata[%0d] addr=%h size=%0d r=%b w=%b got=%h want=%h", t, addr, size, r, w, rd, md); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    applyIdle();
    test_reset();
    test_init_window();
    test_word();
    test_subword();
    test_faults();
    test_misalign();
    test_backpressure();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
